mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_W, default 32, meaning data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, meaning consecutive lost cycles before fetch is forced to win.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have fetch ports: if_req in 1 read request; if_addr in ADDR_W; if_flush in 1 drop pending fetch responses; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-007 SHALL have data ports: d_req in 1; d_we in 4 byte write enables, 0 = read; d_addr in ADDR_W; d_wdata in DATA_W; d_gnt out 1; d_rvalid out 1; d_rdata out DATA_W.
REQ-008 SHALL have memory ports: mem_req out 1; mem_we out 4; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_ready in 1 request accepted; mem_rvalid in 1; mem_rdata in DATA_W.
REQ-009 SHALL have port resp_err  output  1  sticky flag: unexpected memory response.

Function
REQ-010 SHALL treat a request as accepted on a cycle where X_req and X_gnt are both high; at most one grant per cycle.
REQ-011 SHALL compute grants combinationally; no grant when mem_ready=0, when rst=1, or when the tag FIFO is full and the winning request is a read.
REQ-012 SHALL give priority to data requests, except when starve_cnt equals STARVE_MAX, in which case a pending fetch wins.
REQ-013 SHALL increment starve_cnt, saturating at STARVE_MAX, on each cycle with if_req=1 and if_gnt=0; SHALL clear it on an if grant or when if_req=0.
REQ-014 SHALL drive mem_req, mem_we, mem_addr and mem_wdata from the granted requester in the same cycle; mem_we=0 for fetch; mem_req=0 when no grant.
REQ-015 SHALL keep a 2-entry in-order tag FIFO with entry {owner(IF/D), discard}; push on every accepted read (d_we=0 or fetch); accepted writes push nothing and produce no response.
REQ-016 SHALL pop the FIFO head on mem_rvalid and route mem_rdata to the owner's rdata, pulsing that owner's rvalid for one cycle in the same cycle; a head with discard=1 pops with no rvalid.
REQ-017 SHALL permit push and pop in the same cycle, leaving the count unchanged; full is evaluated without pop lookahead.
REQ-018 SHALL, on if_flush=1, set discard on every valid IF-owned entry, including a head popped that cycle, and SHALL force if_gnt=0 that cycle.
REQ-019 SHALL, on mem_rvalid with the FIFO empty, set resp_err=1 (held until reset) and assert no rvalid.
REQ-020 SHALL drive if_rdata/d_rdata = mem_rdata at all times; consumers qualify with rvalid.

Reset
REQ-021 SHALL on rst=1, asynchronously, empty the FIFO and clear starve_cnt=0 and resp_err=0; if_gnt, d_gnt, mem_req, if_rvalid and d_rvalid SHALL be 0 while rst=1.
REQ-022 SHALL discard in-flight transactions on reset mid-operation; a mem_rvalid in the first cycle after reset release sets resp_err.

Verification
REQ-023 Both requesters issue reads continuously, mem_ready=1 -> d_gnt for 4 cycles, if_gnt on the 5th, then the pattern repeats; starve_cnt never exceeds 4.
REQ-024 d read 0x100, then fetch 0x200, mem_rvalid returning 0xAAAA then 0xBBBB -> d_rvalid with 0xAAAA, then if_rvalid with 0xBBBB, in order.
REQ-025 Two fetch reads are outstanding and mem_rvalid is held low -> a third if_req gets no grant; a d write with d_we=0xF is still granted.
REQ-026 A fetch read is outstanding and if_flush pulses, then mem_rvalid returns 0x1234 -> if_rvalid stays 0 and the FIFO is empty afterwards.
REQ-027 mem_rvalid with the FIFO empty -> resp_err=1 and it stays set; rst=1 -> resp_err=0 immediately, without waiting for a clock.
REQ-028 mem_ready=0 with both requests high -> no grant and mem_req=0; once mem_ready=1, d_gnt=1 in that same cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data-priority grant with fetch anti-starvation,
// and a 2-entry in-order tag FIFO that steers read responses to their owner.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    // data port
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    // memory port
    output logic              mem_req,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              resp_err
);

    localparam int unsigned CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt, starve_nxt;
    logic [1:0]       fifo_cnt, fifo_cnt_nxt;
    // bit 0 is the head entry; owner 1 = fetch, 0 = data
    logic [1:0]       owner_q, owner_nxt;
    logic [1:0]       disc_q, disc_nxt, disc_flush;
    logic [1:0]       valid_mask;
    logic             err_nxt;

    logic fetch_ok, fetch_wins, data_wins, win_read, fifo_full, blocked;
    logic pop, push, head_live;

    // Grant selection and same-cycle memory request mux
    always_comb begin
        fetch_ok   = if_req && !if_flush;
        fetch_wins = fetch_ok && (!d_req || (starve_cnt == CNT_W'(STARVE_MAX)));
        data_wins  = d_req && !fetch_wins;
        win_read   = fetch_wins || (data_wins && (d_we == 4'b0000));
        fifo_full  = (fifo_cnt == 2'd2);
        blocked    = rst || !mem_ready || (fifo_full && win_read);
        if_gnt     = fetch_wins && !blocked;
        d_gnt      = data_wins && !blocked;
        mem_req    = if_gnt || d_gnt;
        mem_we     = d_gnt ? d_we : 4'b0000;
        mem_addr   = if_gnt ? if_addr : d_addr;
        mem_wdata  = if_gnt ? DATA_W'(0) : d_wdata;
    end

    // Response routing; a flush in the pop cycle also suppresses the head
    always_comb begin
        valid_mask = {fifo_cnt == 2'd2, fifo_cnt != 2'd0};
        disc_flush = disc_q | (owner_q & valid_mask & {2{if_flush}});
        pop        = mem_rvalid && (fifo_cnt != 2'd0);
        head_live  = pop && !disc_flush[0] && !rst;
        if_rvalid  = head_live && owner_q[0];
        d_rvalid   = head_live && !owner_q[0];
        if_rdata   = mem_rdata;
        d_rdata    = mem_rdata;
    end

    // Next-state: tag FIFO, starvation counter, sticky error
    always_comb begin
        owner_nxt    = owner_q;
        disc_nxt     = disc_flush;
        fifo_cnt_nxt = fifo_cnt;
        starve_nxt   = starve_cnt;
        push         = if_gnt || (d_gnt && (d_we == 4'b0000));
        err_nxt      = resp_err || (mem_rvalid && (fifo_cnt == 2'd0));

        if (pop) begin
            owner_nxt    = {1'b0, owner_q[1]};
            disc_nxt     = {1'b0, disc_flush[1]};
            fifo_cnt_nxt = fifo_cnt - 2'd1;
        end
        if (push) begin
            if (fifo_cnt_nxt == 2'd0) begin
                owner_nxt[0] = if_gnt;
                disc_nxt[0]  = 1'b0;
            end else begin
                owner_nxt[1] = if_gnt;
                disc_nxt[1]  = 1'b0;
            end
            fifo_cnt_nxt = fifo_cnt_nxt + 2'd1;
        end

        if (if_req && !if_gnt) begin
            if (starve_cnt != CNT_W'(STARVE_MAX))
                starve_nxt = starve_cnt + CNT_W'(1);
        end else begin
            starve_nxt = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt   <= 2'd0;
            owner_q    <= 2'b00;
            disc_q     <= 2'b00;
            starve_cnt <= '0;
            resp_err   <= 1'b0;
        end else begin
            fifo_cnt   <= fifo_cnt_nxt;
            owner_q    <= owner_nxt;
            disc_q     <= disc_nxt;
            starve_cnt <= starve_nxt;
            resp_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req, if_flush, if_gnt, if_rvalid;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req, d_gnt, d_rvalid;
    logic [3:0]        d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata, d_rdata;
    logic              mem_req, mem_ready, mem_rvalid;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              resp_err;

    int checks = 0;
    int errors = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if_req = 1'b0; if_addr = 32'h200; if_flush = 1'b0;
        d_req = 1'b0; d_we = 4'h0; d_addr = 32'h100; d_wdata = 32'h0;
        mem_ready = 1'b1; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    endtask

    logic prev_d;

    initial begin
        rst = 1'b1;
        idle();

        // Reset: no grants or responses even with everything requesting
        @(negedge clk);
        if_req = 1'b1; d_req = 1'b1; mem_rvalid = 1'b1;
        #1;
        chk("rst_if_gnt", 32'(if_gnt), 32'd0);
        chk("rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("rst_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);

        @(negedge clk);
        rst = 1'b0; idle();
        #1;
        chk("rel_resp_err", 32'(resp_err), 32'd0);

        // Continuous reads: 4 data grants then 1 fetch grant, repeating
        prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if_req = 1'b1; d_req = 1'b1; d_we = 4'h0;
            mem_rvalid = (k > 0); mem_rdata = 32'(k);
            #1;
            chk("rr_d_gnt", 32'(d_gnt), 32'((k % 5) != 4));
            chk("rr_if_gnt", 32'(if_gnt), 32'((k % 5) == 4));
            chk("rr_mem_addr", mem_addr, ((k % 5) == 4) ? 32'h200 : 32'h100);
            if (k > 0) begin
                chk("rr_d_rvalid", 32'(d_rvalid), 32'(prev_d));
                chk("rr_if_rvalid", 32'(if_rvalid), 32'(!prev_d));
            end
            prev_d = ((k % 5) != 4);
        end
        @(negedge clk);
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #1;
        chk("rr_drain_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("rr_drain_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("rr_resp_err", 32'(resp_err), 32'd0);

        // In-order response routing
        @(negedge clk);
        idle(); d_req = 1'b1; d_addr = 32'h100;
        #1;
        chk("ord_d_gnt", 32'(d_gnt), 32'd1);
        chk("ord_d_addr", mem_addr, 32'h100);
        chk("ord_d_we", 32'(mem_we), 32'd0);
        @(negedge clk);
        idle(); if_req = 1'b1; if_addr = 32'h200;
        #1;
        chk("ord_if_gnt", 32'(if_gnt), 32'd1);
        chk("ord_if_addr", mem_addr, 32'h200);
        @(negedge clk);
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'hAAAA;
        #1;
        chk("ord_rsp1_d_rvalid", 32'(d_rvalid), 32'd1);
        chk("ord_rsp1_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("ord_rsp1_d_rdata", d_rdata, 32'hAAAA);
        @(negedge clk);
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'hBBBB;
        #1;
        chk("ord_rsp2_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("ord_rsp2_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("ord_rsp2_if_rdata", if_rdata, 32'hBBBB);

        // Full FIFO blocks reads but not writes
        @(negedge clk);
        idle(); if_req = 1'b1; if_addr = 32'h300;
        #1;
        chk("full_gnt1", 32'(if_gnt), 32'd1);
        @(negedge clk);
        #1;
        chk("full_gnt2", 32'(if_gnt), 32'd1);
        @(negedge clk);
        #1;
        chk("full_if_blocked", 32'(if_gnt), 32'd0);
        chk("full_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        d_req = 1'b1; d_we = 4'hF; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        #1;
        chk("full_wr_d_gnt", 32'(d_gnt), 32'd1);
        chk("full_wr_if_gnt", 32'(if_gnt), 32'd0);
        chk("full_wr_mem_we", 32'(mem_we), 32'hF);
        chk("full_wr_wdata", mem_wdata, 32'hDEADBEEF);
        @(negedge clk);
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'h11;
        #1;
        chk("full_rsp1_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("full_rsp1_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        mem_rdata = 32'h22;
        #1;
        chk("full_rsp2_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("full_rsp2_if_rdata", if_rdata, 32'h22);

        // Flush discards an outstanding fetch response
        @(negedge clk);
        idle(); if_req = 1'b1; if_addr = 32'h500;
        #1;
        chk("fl_if_gnt", 32'(if_gnt), 32'd1);
        @(negedge clk);
        if_flush = 1'b1;
        #1;
        chk("fl_gnt_forced_off", 32'(if_gnt), 32'd0);
        @(negedge clk);
        idle(); mem_rvalid = 1'b1; mem_rdata = 32'h1234;
        #1;
        chk("fl_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("fl_d_rvalid", 32'(d_rvalid), 32'd0);
        chk("fl_resp_err_pre", 32'(resp_err), 32'd0);

        // Response with empty FIFO: sticky error, async clear by reset
        @(negedge clk);
        mem_rvalid = 1'b1; mem_rdata = 32'h9999;
        #1;
        chk("err_if_rvalid", 32'(if_rvalid), 32'd0);
        chk("err_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("err_set", 32'(resp_err), 32'd1);
        @(negedge clk);
        #1;
        chk("err_sticky", 32'(resp_err), 32'd1);
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; d_req = 1'b1;
        #1;
        chk("err_async_clear", 32'(resp_err), 32'd0);
        chk("err_rst_d_gnt", 32'(d_gnt), 32'd0);
        chk("err_rst_if_gnt", 32'(if_gnt), 32'd0);

        // Reset mid-transaction drops in-flight reads
        @(negedge clk);
        rst = 1'b0; idle(); d_req = 1'b1;
        #1;
        chk("mid_d_gnt", 32'(d_gnt), 32'd1);
        @(negedge clk);
        idle(); rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #1;
        chk("mid_d_rvalid", 32'(d_rvalid), 32'd0);
        @(negedge clk);
        idle();
        #1;
        chk("mid_resp_err", 32'(resp_err), 32'd1);

        // mem_ready gating
        @(negedge clk);
        idle(); mem_ready = 1'b0; if_req = 1'b1; d_req = 1'b1;
        #1;
        chk("rdy0_if_gnt", 32'(if_gnt), 32'd0);
        chk("rdy0_d_gnt", 32'(d_gnt), 32'd0);
        chk("rdy0_mem_req", 32'(mem_req), 32'd0);
        @(negedge clk);
        mem_ready = 1'b1;
        #1;
        chk("rdy1_d_gnt", 32'(d_gnt), 32'd1);
        chk("rdy1_if_gnt", 32'(if_gnt), 32'd0);
        chk("rdy1_mem_req", 32'(mem_req), 32'd1);

        @(negedge clk);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
